// File: rtl/glb_done_intr_ctrl.sv
// Turns per-engine done pulses into sticky ping-pong status/overflow bits with
// W1C clear, per-bit masking and a coalesced, registered level interrupt.

// One status/overflow bit pair; a set on the same cycle as a clear wins.
module glb_done_bit (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rst,
  input  logic pulse,
  input  logic clr,
  output logic status,
  output logic ovf
);
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      status <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      status <= (status & ~clr) | pulse;
      // A pulse landing on a bit that is being cleared is a fresh event, not an overflow.
      ovf    <= (ovf & ~clr) | (pulse & status & ~clr);
    end
  end
endmodule

module glb_done_intr_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int TMO_W   = 16,
  parameter int W       = 2*NUM_SRC
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic [W-1:0]     done_pulse,
  input  logic [W-1:0]     done_mask,
  input  logic             status_clr_en,
  input  logic [W-1:0]     status_clr_data,
  input  logic [TMO_W-1:0] coal_timeout,
  output logic [W-1:0]     done_status,
  output logic [W-1:0]     done_ovf,
  output logic             core_intr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ASSERT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [TMO_W-1:0] cnt, cnt_n;
  logic [W-1:0]     clr_vec;
  logic             pending;

  assign clr_vec = {W{status_clr_en}} & status_clr_data;

  glb_done_bit u_bit [W-1:0] (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .pulse          (done_pulse),
    .clr            (clr_vec),
    .status         (done_status),
    .ovf            (done_ovf)
  );

  // Mask is applied live so unmasking a set bit raises pending at once.
  assign pending = |(done_status & ~done_mask);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      core_intr <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      core_intr <= (state_n == ST_ASSERT);
    end
  end

  // Timeout is captured only when entering WAIT; the counter rests at 0 elsewhere.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          if (coal_timeout == '0) begin
            state_n = ST_ASSERT;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = coal_timeout - TMO_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (!pending) begin
          state_n = ST_IDLE;
        end else if (cnt == '0) begin
          state_n = ST_ASSERT;
        end else begin
          cnt_n = cnt - TMO_W'(1);
        end
      end
      ST_ASSERT: begin
        if (!pending) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_glb_done_intr_ctrl.sv
// Scoreboard bench for glb_done_intr_ctrl: a cycle model pushes expected
// outputs when stimulus is driven; they are popped and compared after the edge.
module tb_glb_done_intr_ctrl;
  localparam int NS = 8;
  localparam int W  = 2*NS;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  pulse, mask, cdata;
  logic          cen;
  logic [TW-1:0] tmo;
  logic [W-1:0]  status, ovf;
  logic          intr;

  glb_done_intr_ctrl #(.NUM_SRC(NS), .TMO_W(TW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rst  (rst),
    .done_pulse      (pulse),
    .done_mask       (mask),
    .status_clr_en   (cen),
    .status_clr_data (cdata),
    .coal_timeout    (tmo),
    .done_status     (status),
    .done_ovf        (ovf),
    .core_intr       (intr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] st;
    logic [W-1:0] ovf;
    logic         intr;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  // reference model: 0 idle, 1 counting down, 2 interrupt raised
  logic [W-1:0]  m_st, m_ovf;
  int            m_ph, m_left;
  logic [W-1:0]  cur_mask;
  logic [TW-1:0] cur_tmo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = '0; m_ovf = '0; m_ph = 0; m_left = 0;
    sb.delete();
  endtask

  task automatic step(input logic [W-1:0] p, input logic ce, input logic [W-1:0] cd);
    logic [W-1:0] c;
    logic         pend;
    exp_t         e, g;
    pulse = p; cen = ce; cdata = cd; mask = cur_mask; tmo = cur_tmo;
    c    = ce ? cd : '0;
    pend = |(m_st & ~cur_mask);
    if (m_ph == 0) begin
      if (pend) begin
        if (cur_tmo == 0) m_ph = 2;
        else begin m_ph = 1; m_left = int'(cur_tmo); end
      end
    end else if (m_ph == 1) begin
      if (!pend) m_ph = 0;
      else begin
        m_left--;
        if (m_left == 0) m_ph = 2;
      end
    end else if (!pend) m_ph = 0;
    m_ovf = (m_ovf & ~c) | (p & m_st & ~c);
    m_st  = (m_st & ~c) | p;
    e.st = m_st; e.ovf = m_ovf; e.intr = (m_ph == 2);
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      g.st = status; g.ovf = ovf; g.intr = intr;
      chk("status", 32'(g.st), 32'(e.st));
      chk("ovf", 32'(g.ovf), 32'(e.ovf));
      chk("intr", 32'(g.intr), 32'(e.intr));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, '0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_intr", 32'(intr), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic basic_flow();
    cur_tmo = '0; cur_mask = '0;
    step(16'h0001, 1'b0, '0);
    chk("t1_status_t1", 32'(status), 32'h0001);
    chk("t1_intr_t1", 32'(intr), 32'd0);
    step('0, 1'b0, '0);
    chk("t1_intr_t2", 32'(intr), 32'd1);
    idle(2);
    step('0, 1'b1, 16'h0001);
    chk("t1_clr_status", 32'(status), 32'd0);
    chk("t1_clr_intr_c1", 32'(intr), 32'd1);
    step('0, 1'b0, '0);
    chk("t1_clr_intr_c2", 32'(intr), 32'd0);
  endtask

  initial begin
    rst = 1'b1; pulse = '0; mask = '0; cen = 1'b0; cdata = '0; tmo = '0;
    cur_mask = '0; cur_tmo = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", 32'(status), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_intr", 32'(intr), 32'd0);
    rst = 1'b0;

    // immediate interrupt and W1C deassertion
    basic_flow();

    // coalescing delay of 3: rise at t+5
    cur_tmo = 16'd3;
    step(16'h0010, 1'b0, '0);
    idle(3);
    chk("t2_intr_t4", 32'(intr), 32'd0);
    step('0, 1'b0, '0);
    chk("t2_intr_t5", 32'(intr), 32'd1);
    step('0, 1'b1, 16'h0010);
    idle(2);
    // clear during WAIT cancels the interrupt
    step(16'h0010, 1'b0, '0);
    idle(2);
    step('0, 1'b1, 16'h0010);
    idle(4);
    chk("t2_cancel_intr", 32'(intr), 32'd0);
    // timeout change in WAIT is ignored
    cur_tmo = 16'd5;
    step(16'h0100, 1'b0, '0);
    step('0, 1'b0, '0);
    cur_tmo = 16'd0;
    idle(6);
    step('0, 1'b1, 16'h0100);
    idle(2);

    // set-wins and overflow on bit 7
    step(16'h0080, 1'b0, '0);
    step(16'h0080, 1'b1, 16'h0080);
    chk("t3_st7_same", 32'(status[7]), 32'd1);
    chk("t3_ovf7_same", 32'(ovf[7]), 32'd0);
    step(16'h0080, 1'b0, '0);
    chk("t3_ovf7_second", 32'(ovf[7]), 32'd1);
    step('0, 1'b1, 16'h0080);
    chk("t3_clr_both", 32'({status[7], ovf[7]}), 32'd0);
    idle(2);

    // masking
    cur_mask = 16'hFFFF;
    step(16'h8001, 1'b0, '0);
    idle(2);
    chk("t4_status", 32'(status), 32'h8001);
    chk("t4_intr_masked", 32'(intr), 32'd0);
    cur_mask = 16'h7FFF;
    step('0, 1'b0, '0);
    idle(2);
    chk("t4_intr_unmasked", 32'(intr), 32'd1);
    cur_mask = 16'hFFFF;
    idle(2);
    chk("t4_intr_remasked", 32'(intr), 32'd0);
    chk("t4_status_kept", 32'(status), 32'h8001);
    cur_mask = '0;
    step('0, 1'b1, 16'hFFFF);
    idle(2);

    // async reset while asserted, then while waiting
    step(16'h0001, 1'b0, '0);
    idle(2);
    async_reset();
    cur_tmo = 16'd4;
    step(16'h0002, 1'b0, '0);
    idle(2);
    async_reset();
    basic_flow();

    // all bits at once, cleared one per cycle
    step(16'hFFFF, 1'b0, '0);
    idle(2);
    for (int i = 0; i < W; i++) begin
      step('0, 1'b1, W'(1) << i);
      if (i < W-1) chk("t6_intr_hold", 32'(intr), 32'd1);
    end
    step('0, 1'b0, '0);
    chk("t6_intr_drop", 32'(intr), 32'd0);
    idle(1);

    if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
